mem_arbiter: RTL
================

// Module: mem_arbiter
// PURPOSE
//   Downstream neighbour of the instruction and data caches. Arbitrates two 128-bit line requesters
//   (I-cache, D-cache) onto the single shared memory port. Uses round-robin fairness.
//   Registers the memory-side request and returns mem_ready/mem_rdata to the granted cache only.
// PARAMETERS
//   ADDR_W   28    line address width (word address >> 2)
//   DATA_W   128   line width, bits
// PORTS
//   clk          in   1       single clock, rising edge
//   proc_reset   in   1       asynchronous, active-high reset
//   i_read       in   1       I-cache line read request, held until i_ready
//   i_write      in   1       I-cache line write request, held until i_ready
//   i_addr       in   ADDR_W  I-cache line address
//   i_wdata      in   DATA_W  I-cache write line
//   i_rdata      out  DATA_W  read line to I-cache
//   i_ready      out  1       one-cycle completion to I-cache
//   d_read/d_write/d_addr/d_wdata/d_rdata/d_ready   same as i_*, for the D-cache
//   mem_read     out  1       registered read request to memory
//   mem_write    out  1       registered write request to memory
//   mem_addr     out  ADDR_W  registered line address
//   mem_wdata    out  DATA_W  registered write line
//   mem_rdata    in   DATA_W  memory read line, valid when mem_ready
//   mem_ready    in   1       memory completion strobe
// BEHAVIOUR
//   Reset: state=IDLE, last_grant=I (D wins the first tie); mem_read/mem_write=0.
//     Reset also clears mem_addr/mem_wdata to 0, i_ready/d_ready to 0 and i_rdata/d_rdata to 0.
//   Valid request: exactly one of rd/wr asserted. rd&wr is ignored and never granted.
//   FSM states: IDLE, GRANT_I, GRANT_D.
//     IDLE: only one side valid -> grant it. Both valid -> grant the side != last_grant.
//       On grant, latch addr/wdata/rd/wr into the mem_* registers and update last_grant.
//       Next state is GRANT_x. No request -> stay in IDLE.
//     GRANT_x: mem_* held stable. When mem_ready=1, x_ready=1 combinationally in the same cycle,
//       x_rdata=mem_rdata for reads, and the next state is IDLE.
//       mem_read/mem_write clear at that edge.
//   The non-granted side sees ready=0 and rdata=0 at all times.
//   Latency: request sampled in IDLE at edge N; mem_* asserted from cycle N+1.
//     x_ready coincides with mem_ready; re-arbitration happens on the first IDLE cycle after.
//     Minimum occupancy is 2 cycles per transaction. Back-to-back requests from one cache
//     (write-back followed by refill) are re-arbitrated in between.
//   Fairness: with both sides requesting continuously, grants alternate D,I,D,I...
//   Requester dropping its request mid-grant is illegal: the latched transaction completes
//     anyway and the ready strobe is still delivered.
//   mem_ready while in IDLE is ignored.
//   Reset mid-transaction: outputs clear immediately (async) and the memory op is abandoned.
//     The memory model must tolerate a request withdrawn without ready.
// STRUCTURE
//   Shared header mem_if_defs.vh: ADDR_W/DATA_W defaults, FSM encodings
//     (IDLE=2'b00, GRANT_I=2'b01, GRANT_D=2'b10), requester IDs (REQ_I=0, REQ_D=1).
//   One sub-module, rr_arb2: takes 2 valid bits and last_grant; returns a one-hot grant.
//     Purely combinational; last_grant is kept in mem_arbiter.
//   mem_arbiter holds the FSM, the mem_* output registers and the ready/rdata return mux.
// TESTING
//   1 Reset mid-GRANT_D with mem_write=1 -> all outputs 0 in the same cycle;
//     after release, IDLE and D wins the first tie.
//   2 I-only read addr=28'h0000010, mem_ready after 3 cycles with rdata=128'hA5..A5
//     -> mem_read=1 for exactly those cycles; i_ready=1 for 1 cycle with that data; d_ready stays 0.
//   3 Both request after reset, D write addr=28'h0000003 and I read -> D served first
//     (mem_write, d_wdata on mem_wdata); I granted on the first IDLE cycle after d_ready.
//   4 Both held continuously for 6 transactions -> grant order D,I,D,I,D,I;
//     no side ever gets two grants in a row.
//   5 D asserts d_read=1 and d_write=1 together, I idle -> no grant; mem_read=mem_write=0;
//     state remains IDLE.
//   6 D write-back then immediate refill on the same line, I idle -> two separate grants
//     with one IDLE cycle between; mem_addr differs (victim tag vs new tag).

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_arbiter_pkg
//   Shared definitions for the cache-to-memory arbiter:
//     - default line address / data widths
//     - arbiter FSM state encoding
//     - requester identifiers (used as bit positions in valid/grant vectors)
//     - helper that decides whether a requester's rd/wr pair is a legal request
// -----------------------------------------------------------------------------
package mem_arbiter_pkg;

    // Line address is the word address >> 2; a line is 128 bits.
    localparam int ADDR_W_DEF = 28;
    localparam int DATA_W_DEF = 128;

    // Requester identifiers; also the bit index into valid/grant vectors.
    localparam int REQ_I = 0;
    localparam int REQ_D = 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_GRANT_I = 2'b01,
        ST_GRANT_D = 2'b10
    } arb_state_e;

    // A request is only serviceable when exactly one of read/write is set.
    // rd & wr together is treated as no request at all.
    function automatic logic req_valid(input logic rd, input logic wr);
        return rd ^ wr;
    endfunction

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
//   Two-way round-robin grant logic, purely combinational.
//   Ports:
//     valid      in  [1:0]  per-requester valid (index REQ_I / REQ_D)
//     last_grant in  1      requester id that won the previous arbitration
//     grant      out [1:0]  one-hot grant, all-zero when nothing is valid
//   The last_grant history register lives in the caller.
// -----------------------------------------------------------------------------
module rr_arb2
    import mem_arbiter_pkg::*;
(
    input  logic [1:0] valid,
    input  logic       last_grant,
    output logic [1:0] grant
);

    always_comb begin
        grant = '0;
        if (valid[REQ_I] && valid[REQ_D]) begin
            // Tie: the side that did not win last time goes first.
            if (last_grant == 1'(REQ_D)) begin
                grant[REQ_I] = 1'b1;
            end else begin
                grant[REQ_D] = 1'b1;
            end
        end else begin
            grant = valid;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//   Arbitrates the I-cache and D-cache line requesters onto the single shared
//   memory port with round-robin fairness. The memory-side request is
//   registered; completion (ready + read data) is returned only to the cache
//   that owns the current transaction.
//   Ports:
//     clk, proc_reset                  clock, asynchronous active-high reset
//     i_read/i_write/i_addr/i_wdata    I-cache request (held until i_ready)
//     i_rdata/i_ready                  I-cache completion
//     d_*                              same for the D-cache
//     mem_read/mem_write/mem_addr/mem_wdata   registered memory request
//     mem_rdata/mem_ready              memory completion
// -----------------------------------------------------------------------------
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              proc_reset,

    input  logic              i_read,
    input  logic              i_write,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ready,

    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,

    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    arb_state_e        state_q,      state_d;
    logic              last_grant_q, last_grant_d;
    logic              mem_read_q,   mem_read_d;
    logic              mem_write_q,  mem_write_d;
    logic [ADDR_W-1:0] mem_addr_q,   mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q,  mem_wdata_d;

    logic [1:0] req_vld;
    logic [1:0] grant;

    assign req_vld[REQ_I] = req_valid(i_read, i_write);
    assign req_vld[REQ_D] = req_valid(d_read, d_write);

    rr_arb2 u_rr_arb2 (
        .valid      (req_vld),
        .last_grant (last_grant_q),
        .grant      (grant)
    );

    // Next-state and memory-request register inputs.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        mem_read_d   = mem_read_q;
        mem_write_d  = mem_write_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;

        unique case (state_q)
            ST_IDLE: begin
                // mem_ready is deliberately ignored here.
                if (grant[REQ_D]) begin
                    state_d      = ST_GRANT_D;
                    last_grant_d = 1'(REQ_D);
                    mem_read_d   = d_read;
                    mem_write_d  = d_write;
                    mem_addr_d   = d_addr;
                    mem_wdata_d  = d_wdata;
                end else if (grant[REQ_I]) begin
                    state_d      = ST_GRANT_I;
                    last_grant_d = 1'(REQ_I);
                    mem_read_d   = i_read;
                    mem_write_d  = i_write;
                    mem_addr_d   = i_addr;
                    mem_wdata_d  = i_wdata;
                end
            end

            ST_GRANT_I, ST_GRANT_D: begin
                // The latched transaction runs to completion even if the
                // requester drops its request; address/data stay as they are.
                if (mem_ready) begin
                    state_d     = ST_IDLE;
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                end
            end

            default: begin
                state_d     = ST_IDLE;
                mem_read_d  = 1'b0;
                mem_write_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge proc_reset) begin
        if (proc_reset) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'(REQ_I);   // D wins the first tie
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

    // Completion return: ready tracks mem_ready in the owning grant state only,
    // and read data is exposed only on a read completion; otherwise zero.
    always_comb begin
        i_ready = (state_q == ST_GRANT_I) && mem_ready;
        d_ready = (state_q == ST_GRANT_D) && mem_ready;
        i_rdata = (i_ready && mem_read_q) ? mem_rdata : '0;
        d_rdata = (d_ready && mem_read_q) ? mem_rdata : '0;
    end

endmodule
